// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register file arbiter.
// REGFILE_ARB_PRIO_EN selects fixed-priority arbitration; default is round-robin.
package regfile_arb_pkg;

    localparam int RF_DEPTH = 32;
    localparam int RF_WIDTH = 16;

    localparam logic [2:0] RF_EN_RD1 = 3'b001;
    localparam logic [2:0] RF_EN_RD2 = 3'b010;
    localparam logic [2:0] RF_EN_WR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from ptr+1, or lowest index when
// REGFILE_ARB_PRIO_EN is defined (no pointer port in that build).
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
`ifndef REGFILE_ARB_PRIO_EN
    input  logic [IW-1:0]   ptr,
`endif
    output logic            any,
    output logic [IW-1:0]   win_idx,
    output logic [NREQ-1:0] win_oh
);

    // Scan requesters in priority order and keep the first one found.
    always_comb begin
        any     = 1'b0;
        win_idx = '0;
        win_oh  = '0;
`ifdef REGFILE_ARB_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            win_idx = req[k] ? IW'(k) : win_idx;
            any     = any | req[k];
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            int sum;
            int idx;
            sum     = int'(ptr) + k;
            idx     = (sum >= NREQ) ? (sum - NREQ) : sum;
            win_idx = (!any && req[idx]) ? IW'(idx) : win_idx;
            any     = any | req[idx];
        end
`endif
        win_oh[win_idx] = any;
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register file between NREQ requesters, one word transaction at a time.
// REGFILE_ARB_PRIO_EN: fixed priority (lowest index wins); otherwise round-robin.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AW     = 5,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [2:0]        rf_valid,
    output logic [AW-1:0]     rf_raddr,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    input  logic [DW-1:0]     rf_rdata
);

    localparam int         IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    arb_state_e      state_r;
    arb_state_e      state_s;
    logic [3:0]      cnt_r;
    logic            cur_we_r;
    logic [NREQ-1:0] cur_oh_r;
    logic            any_s;
    logic [IW-1:0]   win_idx_s;
    logic [NREQ-1:0] win_oh_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            sel_we_s;
`ifndef REGFILE_ARB_PRIO_EN
    logic [IW-1:0]   ptr_r;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
`ifndef REGFILE_ARB_PRIO_EN
        .ptr     (ptr_r),
`endif
        .any     (any_s),
        .win_idx (win_idx_s),
        .win_oh  (win_oh_s)
    );

    assign sel_addr_s  = addr[int'(win_idx_s) * AW +: AW];
    assign sel_wdata_s = wdata[int'(win_idx_s) * DW +: DW];
    assign sel_we_s    = we[win_idx_s];

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (any_s) state_s = ST_ISSUE; else state_s = ST_IDLE;
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT:  if (cnt_r == 4'd0) state_s = ST_DONE; else state_s = ST_WAIT;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register and registered outputs; each output lags its state by one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            cur_we_r <= 1'b0;
            cur_oh_r <= '0;
            gnt      <= '0;
            ack      <= '0;
            rdata    <= '0;
            busy     <= 1'b0;
            rf_valid <= 3'b000;
            rf_raddr <= '0;
            rf_waddr <= '0;
            rf_wdata <= '0;
`ifndef REGFILE_ARB_PRIO_EN
            ptr_r    <= IW'(NREQ - 1);
`endif
        end else begin
            state_r  <= state_s;
            gnt      <= '0;
            ack      <= '0;
            rf_valid <= 3'b000;
            busy     <= (state_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        gnt      <= win_oh_s;
                        cur_oh_r <= win_oh_s;
                        cur_we_r <= sel_we_s;
                        rf_raddr <= sel_addr_s;
                        rf_waddr <= sel_addr_s;
                        rf_wdata <= sel_wdata_s;
`ifndef REGFILE_ARB_PRIO_EN
                        ptr_r    <= win_idx_s;
`endif
                    end
                end
                ST_ISSUE: begin
                    rf_valid <= cur_we_r ? RF_EN_WR : RF_EN_RD1;
                    cnt_r    <= CNT_INIT;
                end
                ST_WAIT: begin
                    // Read data is sampled on the edge that leaves WAIT.
                    if (cnt_r == 4'd0) begin
                        if (!cur_we_r) rdata <= rf_rdata;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DONE: ack <= cur_oh_r;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized scoreboard bench for regfile_arbiter with a behavioural register file.
// Honours REGFILE_ARB_PRIO_EN in its reference arbitration rule.
module tb_regfile_arbiter;

    localparam int NREQ   = 3;
    localparam int AW     = 5;
    localparam int DW     = 16;
    localparam int RD_LAT = 4;
`ifdef REGFILE_ARB_PRIO_EN
    localparam int IDLE_MAX  = 15;
    localparam int WAIT_LIM  = 2000;
`else
    localparam int IDLE_MAX  = 4;
    localparam int WAIT_LIM  = 200;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [2:0]        rf_valid;
    logic [AW-1:0]     rf_raddr;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic [DW-1:0]     rf_rdata;

    regfile_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy), .rf_valid(rf_valid),
        .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-requester drive variables, packed onto the DUT buses.
    logic          d_req   [NREQ];
    logic          d_we    [NREQ];
    logic [AW-1:0] d_addr  [NREQ];
    logic [DW-1:0] d_wdata [NREQ];

    always_comb begin
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = d_req[i];
            we[i]              = d_we[i];
            addr[i*AW +: AW]   = d_addr[i];
            wdata[i*DW +: DW]  = d_wdata[i];
        end
    end

    // Behavioural register file: writes land while enabled, reads appear RD_LAT cycles later.
    logic [DW-1:0] rf_mem  [32];
    logic [DW-1:0] ref_mem [32];
    int            rd_cd;
    logic          rd_pend;
    logic [AW-1:0] rd_pa;

    initial begin
        rd_pend  = 1'b0;
        rd_cd    = 0;
        rd_pa    = '0;
        rf_rdata = '0;
        forever begin
            @(negedge clk);
            if (rf_valid[2]) rf_mem[rf_waddr] = rf_wdata;
            if (rf_valid[0]) begin
                rd_pend = 1'b1;
                rd_cd   = RD_LAT - 1;
                rd_pa   = rf_raddr;
            end else if (rd_pend) begin
                rd_cd = rd_cd - 1;
            end
            if (rd_pend && rd_cd == 0) begin
                rf_rdata = rf_mem[rd_pa];
                rd_pend  = 1'b0;
            end else begin
                rf_rdata = DW'($urandom);
            end
        end
    end

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference arbitration rule straight from the requester ordering.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
`ifdef REGFILE_ARB_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    typedef struct {
        int            idx;
        logic          we;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    logic          m_act;
    int            m_g;
    logic          m_we;
    logic [DW-1:0] m_rd;
    int            m_ptr;
    int            next_free;
    logic [DW-1:0] last_read;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;

    // Monitor: predicts each cycle's outputs and retires acks against the scoreboard.
    initial begin
        m_act = 1'b0; m_g = 0; m_we = 1'b0; m_rd = '0; m_ptr = NREQ - 1;
        next_free = 0; last_read = '0; e_addr = '0; e_wdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                chk("reset_outputs", 64'({gnt, ack, busy, rf_valid, rf_raddr, rf_waddr, rf_wdata, rdata}), 64'd0);
                m_ptr = NREQ - 1; m_act = 1'b0; next_free = cyc + 1;
                last_read = '0; e_addr = '0; e_wdata = '0;
                sb.delete();
            end else begin
                logic [NREQ-1:0] eg;
                logic [2:0]      ev;
                logic            eb;
                eg = '0;
                if (cyc >= next_free && req != '0) begin
                    int w;
                    exp_t e;
                    w       = model_pick(req, m_ptr);
                    m_ptr   = w;
                    eg[w]   = 1'b1;
                    m_act   = 1'b1;
                    m_g     = cyc;
                    m_we    = we[w];
                    e_addr  = addr[w*AW +: AW];
                    e_wdata = wdata[w*DW +: DW];
                    if (m_we) ref_mem[e_addr] = e_wdata;
                    m_rd    = ref_mem[e_addr];
                    e.idx = w; e.we = m_we; e.data = m_rd; e.due = cyc + RD_LAT + 2;
                    sb.push_back(e);
                    next_free = cyc + RD_LAT + 3;
                end
                chk("gnt", 64'(gnt), 64'(eg));
                ev = (m_act && cyc == m_g + 1) ? (m_we ? 3'b100 : 3'b001) : 3'b000;
                chk("rf_valid", 64'(rf_valid), 64'(ev));
                if (m_act && !m_we && cyc == m_g + RD_LAT + 1) last_read = m_rd;
                eb = m_act && (cyc <= m_g + RD_LAT + 1);
                chk("busy", 64'(busy), 64'(eb));
                chk("rdata_hold", 64'(rdata), 64'(last_read));
                chk("rf_bus", 64'({rf_raddr, rf_waddr, rf_wdata}), 64'({e_addr, e_addr, e_wdata}));
                if (ack != '0) begin
                    if (sb.size() == 0) begin
                        chk("ack_unexpected", 64'(ack), 64'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("ack_onehot", 64'(ack), 64'd1 << e.idx);
                        chk("ack_latency", 64'(cyc), 64'(e.due));
                        if (!e.we) chk("ack_rdata", 64'(rdata), 64'(e.data));
                    end
                end else if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("ack_timeout", 64'(ack), 64'd1 << sb[0].idx);
                    void'(sb.pop_front());
                end
                if (m_act && cyc == m_g + RD_LAT + 2) m_act = 1'b0;
            end
        end
    end

    task automatic wait_gnt(input int i);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[i] && n < WAIT_LIM);
        if (!gnt[i]) chk("gnt_wait", 64'(gnt[i]), 64'd1);
    endtask

    task automatic wait_ack(input int i, output logic [DW-1:0] rd);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack[i] && n < WAIT_LIM);
        if (!ack[i]) chk("ack_wait", 64'(ack[i]), 64'd1);
        rd = rdata;
    endtask

    task automatic do_txn(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd);
        @(negedge clk);
        d_req[i] = 1'b1; d_we[i] = w; d_addr[i] = a; d_wdata[i] = d;
        wait_gnt(i);
        d_req[i] = 1'b0;
        wait_ack(i, rd);
    endtask

    task automatic hold_reads(input int i, input logic [AW-1:0] a, input int n);
        @(negedge clk);
        d_req[i] = 1'b1; d_we[i] = 1'b0; d_addr[i] = a;
        repeat (n) wait_gnt(i);
        d_req[i] = 1'b0;
    endtask

    task automatic new_fields(input int i);
        d_we[i]    = 1'($urandom_range(0, 1));
        d_addr[i]  = AW'($urandom_range(0, 31));
        d_wdata[i] = DW'($urandom);
    endtask

    task automatic driver(input int i, input int n);
        logic keep = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (!keep) begin
                repeat ($urandom_range(0, IDLE_MAX)) @(negedge clk);
                @(negedge clk);
                new_fields(i);
                d_req[i] = 1'b1;
            end
            if (!keep && $urandom_range(0, 7) == 0) begin
                @(negedge clk);
                if (!gnt[i]) begin
                    d_req[i] = 1'b0;
                    continue;
                end
            end else begin
                wait_gnt(i);
            end
            keep = ($urandom_range(0, 1) == 1);
            if (keep) new_fields(i);
            else d_req[i] = 1'b0;
        end
        d_req[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rd;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
        end
        for (int a = 0; a < 32; a++) begin
            rf_mem[a]  = DW'($urandom);
            ref_mem[a] = rf_mem[a];
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        do_txn(0, 1'b1, 5'd5, 16'hBEEF, rd);
        do_txn(0, 1'b0, 5'd5, 16'h0000, rd);
        chk("beef_readback", 64'(rd), 64'h0000_0000_0000_BEEF);

        fork
            hold_reads(0, 5'd1, 4);
            hold_reads(1, 5'd2, 4);
        join
        repeat (RD_LAT + 6) @(negedge clk);

        // Abort a read of address 7 while the DUT waits on the register file.
        @(negedge clk);
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 5'd7;
        wait_gnt(0);
        d_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_txn(0, 1'b0, 5'd7, 16'h0000, rd);
        chk("read7_after_reset", 64'(rd), 64'(ref_mem[7]));

        for (int i = 0; i < NREQ; i++) begin
            fork
                automatic int k = i;
                driver(k, 25);
            join_none
        end
        wait fork;
        repeat (RD_LAT + 10) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Request/grant arbiter that shares the 32 x 16-bit register file between NREQ independent requesters, such as the instruction processor and a debug/host loader. It accepts one single-word read or write transaction at a time. It drives the register file's 3-bit port-enable vector, addresses and write data, waits out the file's read latency, and returns an acknowledge and the read data to the winning requester. Arbitration is round-robin by default and fixed-priority when configured.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 5, register address width
- DW, 16, data width
- RD_LAT, 1, cycles from enable deassertion to valid `rf_rdata` (1..15)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester transaction request, level
- we  in  NREQ  per-requester write flag (1 = write, 0 = read)
- addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  flattened write data, same packing
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted and latched
- ack  out  NREQ  one-hot, one-cycle pulse: transaction complete
- rdata  out  DW  read result, valid while `ack` is high
- busy  out  1  high in every state except IDLE
- rf_valid  out  3  register file enables: bit0 read port 1, bit1 read port 2 (always 0), bit2 write port
- rf_raddr  out  AW  read port 1 address
- rf_waddr  out  AW  write port address
- rf_wdata  out  DW  write data
- rf_rdata  in  DW  read port 1 data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any `req` bit is high at an edge, pick winner w.
  - Latch `we[w]`, `addr[w]` and `wdata[w]` into `rf_*`.
  - Pulse `gnt[w]`, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - `rf_valid` = 3'b001 (read) or 3'b100 (write) for exactly one cycle.
  - Load the wait counter with RD_LAT-1, go to WAIT.
- WAIT:
  - `rf_valid` = 0.
  - Decrement the counter; when it is 0, go to DONE.
  - Reads capture `rf_rdata` into `rdata` on the exit edge.
  - Writes also pass through WAIT so latency is uniform.
- DONE: pulse `ack[w]`, go to IDLE.
- Round-robin:
  - A pointer holds the last winner.
  - The search starts at pointer+1 and wraps from NREQ-1 to 0.
  - The pointer updates only on grant.
- Requester rules:
  - Hold `req`/`we`/`addr`/`wdata` stable until `gnt` is seen; they may change after that.
  - Keeping `req` high after `ack` counts as a new request.
- `rdata` holds its last read value across write transactions.
- `rf_raddr`, `rf_waddr` and `rf_wdata` hold their values until the next grant.

## Timing
- Reset values: state IDLE, RR pointer NREQ-1 (requester 0 wins first), counter 0, and every output 0: `gnt`, `ack`, `rdata`, `busy`, `rf_valid`, `rf_raddr`, `rf_waddr`, `rf_wdata`.
- Request seen at edge E0 gives:
  - `gnt` high during E0→E1;
  - `rf_valid` high during E1→E2;
  - `ack` high during (E2+RD_LAT)→(E3+RD_LAT).
- Occupancy is 3+RD_LAT cycles per transaction. The next arbitration happens at edge E3+RD_LAT at the earliest, since `ack` and IDLE overlap that edge.
- Simultaneous requests: exactly one grant per arbitration; losers stay pending with no starvation.
- `req` dropped before grant: no transaction.
- `req` dropped after grant: the transaction completes normally.
- Reset asserted mid-transaction:
  - Abort, with no `ack` for the aborted transaction.
  - A write already issued in ISSUE may have reached the register file.
  - All outputs return to their reset values on the next edge.

## Configuration
- `REGFILE_ARB_PRIO_EN` defined: fixed priority, lowest index wins every arbitration. The RR pointer is not built.
- Undefined: round-robin as above.

## Structure
- Package `regfile_arb_pkg` holds:
  - the state enum;
  - enable constants RF_EN_RD1 = 3'b001, RF_EN_RD2 = 3'b010, RF_EN_WR = 3'b100;
  - the register file geometry constants (32 entries, 16-bit).
- One sub-module, `rr_pick`: combinational one-hot picker taking a request vector and pointer and returning the winner index and one-hot vector. It reduces to a priority encoder under `REGFILE_ARB_PRIO_EN`.

## Test plan
- Reset then idle, no requests: all outputs 0, `busy` 0 for 20 cycles.
- Requester 0 writes 16'hBEEF to address 5, then reads address 5:
  - `gnt` comes 1 cycle after the request;
  - `rf_valid` = 3'b100, then 3'b001;
  - `ack` comes RD_LAT+2 cycles after `gnt`;
  - `rdata` = 16'hBEEF.
- Requesters 0 and 1 both hold `req` continuously, reading addresses 1 and 2: grants alternate 0,1,0,1, and each `rdata` matches its preloaded value.
- Same as the previous case with `REGFILE_ARB_PRIO_EN`: only requester 0 is ever granted.
- `rst_n` low during WAIT of a read of address 7: no `ack`, outputs 0, and a new request after reset is granted normally.
- Sweep RD_LAT in {1,4}: `ack`-to-`gnt` distance equals RD_LAT+2 cycles.
